onehot_capture_counter: RTL
===========================

Name: onehot_capture_counter

Overview:
- Downstream consumer of the 2-to-4 decoder's one-hot outputs y0..y3.
- Samples the decoder outputs when in_valid is high and checks that exactly one line is asserted.
- Keeps a saturating event counter per output line, plus an error counter for illegal codes.
- All counters and the last legal decoded index are readable over a registered read port.

Parameters:
- CNT_W, default 8: width of each event and error counter (valid range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample y0..y3 this cycle.
- y0  input  1  decoder output line 0.
- y1  input  1  decoder output line 1.
- y2  input  1  decoder output line 2.
- y3  input  1  decoder output line 3.
- clear  input  1  synchronous clear of all counters, last index and the sticky error.
- rd_en  input  1  read request.
- rd_sel  input  3  read address.
- rd_data  output  CNT_W  read data, registered.
- rd_valid  output  1  one-cycle pulse, one cycle after rd_en.
- onehot_err  output  1  sticky flag: an illegal code was sampled.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: cnt0..cnt3 = 0, err_cnt = 0, last_idx = 0, onehot_err = 0, rd_data = 0, rd_valid = 0.
- Reset asserted mid-operation clears all state immediately. Any pending read is dropped (rd_valid = 0).
- Sample, only when in_valid = 1:
  - Code {y3,y2,y1,y0} with exactly one bit set is legal.
  - Legal code: cnt[i] increments, where i is the asserted line; last_idx <= i.
  - Illegal code (0000 or two or more bits set): err_cnt increments, onehot_err <= 1; cnt0..cnt3 and last_idx are unchanged.
- in_valid = 0: no counter changes, whatever the y-line values.
- Saturation: every counter stops at 2^CNT_W-1 and never wraps. Further hits leave the value unchanged.
- Update latency: a counter reflects the sample on the clock edge that samples it, i.e. it is readable by an rd_en issued the following cycle.
- Clear:
  - clear = 1 zeroes cnt0..cnt3, err_cnt, last_idx and onehot_err on the next edge.
  - clear has priority over a same-cycle in_valid sample; that sample is discarded entirely.
- Read port, rd_en = 1 at edge t: rd_data and rd_valid = 1 are presented after edge t and hold for one cycle.
- Read address map:
  - rd_sel 0..3: cnt0..cnt3.
  - rd_sel 4: err_cnt.
  - rd_sel 5: last_idx, zero-extended to CNT_W.
  - rd_sel 6: see Optional Feature.
  - rd_sel 7: 0.
- rd_en = 0: rd_valid = 0 and rd_data holds its previous value.
- Simultaneous read and update (sample or clear in the same cycle as rd_en): the read returns the pre-update value. No forwarding.
- Back-to-back reads are supported every cycle, with no bubbles.
- onehot_err is cleared only by clear or reset.

Optional Feature:
- Macro: ONEHOT_TOTAL_CNT_EN.
- Defined:
  - Adds a CNT_W-bit saturating total_cnt that increments on every in_valid sample, legal or illegal.
  - total_cnt is readable at rd_sel 6.
  - total_cnt is zeroed by reset and by clear; clear also discards that cycle's increment.
- Not defined: no total_cnt register exists, and rd_sel 6 reads 0.

Test Plan:
- Reset, then read rd_sel 0..7 back to back -> rd_valid pulses every cycle, all rd_data = 0, onehot_err = 0.
- Drive codes 0001, 0100, 0100, 1000 with in_valid = 1, then read -> cnt0=1, cnt1=0, cnt2=2, cnt3=1, last_idx=3, err_cnt=0.
- Drive 0000, then 0110, with in_valid = 1 -> err_cnt=2, onehot_err=1, last_idx unchanged. Drive 0010 with in_valid = 0 -> cnt1 stays 0.
- CNT_W = 2: apply 5 samples of 0001 -> cnt0 = 3 (saturated, not 0 or 1).
- clear together with in_valid (0010) and rd_en (rd_sel 4, err_cnt previously 2) -> rd_data = 2; next read of cnt1 = 0; onehot_err = 0.
- With ONEHOT_TOTAL_CNT_EN: 3 legal + 2 illegal samples -> rd_sel 6 = 5. Without the macro -> rd_sel 6 = 0.
- Assert rst_n low mid-stream, between samples -> all outputs 0 immediately; first read after release returns 0.

Source files
------------

// File: rtl/onehot_capture_counter.sv
// rtl/onehot_capture_counter.sv - one-hot decoder output checker with saturating per-line counters
// Optional feature macro: ONEHOT_TOTAL_CNT_EN adds a saturating total sample counter at rd_sel 6.
module onehot_capture_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             onehot_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       code;
  logic             legal;
  logic [1:0]       hit_idx;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       last_idx;
  logic [CNT_W-1:0] rd_mux;
`ifdef ONEHOT_TOTAL_CNT_EN
  logic [CNT_W-1:0] total_cnt;
`endif

  assign code = {y3, y2, y1, y0};

  // Classify the sampled code and locate the single asserted line
  always_comb begin
    legal   = 1'b0;
    hit_idx = 2'd0;
    case (code)
      4'b0001: begin legal = 1'b1; hit_idx = 2'd0; end
      4'b0010: begin legal = 1'b1; hit_idx = 2'd1; end
      4'b0100: begin legal = 1'b1; hit_idx = 2'd2; end
      4'b1000: begin legal = 1'b1; hit_idx = 2'd3; end
      default: begin legal = 1'b0; hit_idx = 2'd0; end
    endcase
  end

  // Event/error counters, last legal index and sticky error; clear beats a same-cycle sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      err_cnt    <= '0;
      last_idx   <= 2'd0;
      onehot_err <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      err_cnt    <= '0;
      last_idx   <= 2'd0;
      onehot_err <= 1'b0;
    end else if (in_valid) begin
      if (legal) begin
        if (cnt[hit_idx] != CNT_MAX) cnt[hit_idx] <= cnt[hit_idx] + CNT_ONE;
        last_idx <= hit_idx;
      end else begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
        onehot_err <= 1'b1;
      end
    end
  end

`ifdef ONEHOT_TOTAL_CNT_EN
  // Count every accepted sample, legal or not; saturates like the other counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cnt <= '0;
    end else if (clear) begin
      total_cnt <= '0;
    end else if (in_valid && (total_cnt != CNT_MAX)) begin
      total_cnt <= total_cnt + CNT_ONE;
    end
  end
`endif

  // Read address decode from the current (pre-update) register values
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd0: rd_mux = cnt[0];
      3'd1: rd_mux = cnt[1];
      3'd2: rd_mux = cnt[2];
      3'd3: rd_mux = cnt[3];
      3'd4: rd_mux = err_cnt;
      3'd5: rd_mux = CNT_W'(last_idx);
`ifdef ONEHOT_TOTAL_CNT_EN
      3'd6: rd_mux = total_cnt;
`else
      3'd6: rd_mux = '0;
`endif
      default: rd_mux = '0;
    endcase
  end

  // Registered read port: data captured on rd_en, valid pulses for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule
